// File: rtl/rps_match_controller.sv
`default_nettype none
// ============================================================================
// Module   : rpsJudge_continuous_jdl25175
// Brief    : Combinational Rock/Paper/Scissors/Lizard/Spock judge. Compares
//            two legal move codes and flags p1 win, p2 win or tie.
// Revision : 1.0 - initial release
// ============================================================================
module rpsJudge_continuous_jdl25175 (
    input  logic [2:0] p1_move,
    input  logic [2:0] p2_move,
    output logic       p1_win,
    output logic       p2_win,
    output logic       tie
);

    localparam logic [2:0] c_ROCK     = 3'b001;
    localparam logic [2:0] c_PAPER    = 3'b010;
    localparam logic [2:0] c_SCISSORS = 3'b011;
    localparam logic [2:0] c_LIZARD   = 3'b100;
    localparam logic [2:0] c_SPOCK    = 3'b101;

    // True when move a defeats move b; illegal codes never defeat anything
    function automatic logic beats(input logic [2:0] a, input logic [2:0] b);
        logic w_res;
        w_res = 1'b0;
        case (a)
            c_ROCK:     w_res = (b == c_SCISSORS) || (b == c_LIZARD);
            c_PAPER:    w_res = (b == c_ROCK)     || (b == c_SPOCK);
            c_SCISSORS: w_res = (b == c_PAPER)    || (b == c_LIZARD);
            c_LIZARD:   w_res = (b == c_PAPER)    || (b == c_SPOCK);
            c_SPOCK:    w_res = (b == c_ROCK)     || (b == c_SCISSORS);
            default:    w_res = 1'b0;
        endcase
        return w_res;
    endfunction

    assign p1_win = beats(p1_move, p2_move);
    assign p2_win = beats(p2_move, p1_move);
    assign tie    = (p1_move == p2_move);

endmodule

// ============================================================================
// Module   : rps_match_controller
// Brief    : Best-of-N match sequencer. Collects one move per player through
//            valid/ack handshakes, judges the latched pair, keeps scores and
//            declares the match winner. Every output is registered.
// Revision : 1.0 - initial release
// ============================================================================
module rps_match_controller #(
    parameter int WIN_TARGET = 3,
    parameter int SCORE_W    = 3,
    parameter int RND_W      = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               p1_valid,
    input  logic [2:0]         p1_move,
    input  logic               p2_valid,
    input  logic [2:0]         p2_move,
    output logic               p1_ack,
    output logic               p2_ack,
    output logic               p1_err,
    output logic               p2_err,
    output logic               round_done,
    output logic               round_p1win,
    output logic               round_p2win,
    output logic               round_tie,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [RND_W-1:0]   round_cnt,
    output logic               match_done,
    output logic [1:0]         match_winner,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_JUDGE   = 3'd2,
        S_RESULT  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [SCORE_W-1:0] c_TARGET   = SCORE_W'(WIN_TARGET);
    localparam logic [SCORE_W-1:0] c_SCORE_1  = SCORE_W'(1);
    localparam logic [RND_W-1:0]   c_RND_1    = RND_W'(1);
    localparam logic [RND_W-1:0]   c_RND_MAX  = {RND_W{1'b1}};

    state_t               r_state, w_state_nxt;

    // Latched moves and per-player hold flags
    logic [2:0]           r_m1, r_m2, w_m1_nxt, w_m2_nxt;
    logic                 r_h1, r_h2, w_h1_nxt, w_h2_nxt;

    // Registered output images
    logic                 r_p1_ack, r_p2_ack, r_p1_err, r_p2_err, r_round_done;
    logic                 w_p1_ack_nxt, w_p2_ack_nxt, w_p1_err_nxt, w_p2_err_nxt;
    logic                 w_round_done_nxt;
    logic                 r_rp1w, r_rp2w, r_rtie, w_rp1w_nxt, w_rp2w_nxt, w_rtie_nxt;
    logic [SCORE_W-1:0]   r_s1, r_s2, w_s1_nxt, w_s2_nxt;
    logic [RND_W-1:0]     r_rc, w_rc_nxt;
    logic                 r_match_done, w_match_done_nxt;
    logic [1:0]           r_winner, w_winner_nxt;
    logic                 r_busy, w_busy_nxt;

    // Handshake qualification and judge results
    logic                 w_p1_legal, w_p2_legal, w_acc1, w_acc2;
    logic                 w_j_p1win, w_j_p2win, w_j_tie;

    assign w_p1_legal = (p1_move != 3'd0) && (p1_move <= 3'd5);
    assign w_p2_legal = (p2_move != 3'd0) && (p2_move <= 3'd5);
    assign w_acc1     = p1_valid && w_p1_legal && !r_h1;
    assign w_acc2     = p2_valid && w_p2_legal && !r_h2;

    rpsJudge_continuous_jdl25175 u_judge (
        .p1_move (r_m1),
        .p2_move (r_m2),
        .p1_win  (w_j_p1win),
        .p2_win  (w_j_p2win),
        .tie     (w_j_tie)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and next values of every registered output
    always_comb begin
        w_state_nxt      = r_state;
        w_m1_nxt         = r_m1;
        w_m2_nxt         = r_m2;
        w_h1_nxt         = r_h1;
        w_h2_nxt         = r_h2;
        w_p1_ack_nxt     = 1'b0;
        w_p2_ack_nxt     = 1'b0;
        w_p1_err_nxt     = 1'b0;
        w_p2_err_nxt     = 1'b0;
        w_round_done_nxt = 1'b0;
        w_rp1w_nxt       = r_rp1w;
        w_rp2w_nxt       = r_rp2w;
        w_rtie_nxt       = r_rtie;
        w_s1_nxt         = r_s1;
        w_s2_nxt         = r_s2;
        w_rc_nxt         = r_rc;
        w_winner_nxt     = r_winner;

        case (r_state)
            S_IDLE, S_DONE: begin
                // A new match wipes everything from the previous one
                if (start) begin
                    w_state_nxt  = S_COLLECT;
                    w_h1_nxt     = 1'b0;
                    w_h2_nxt     = 1'b0;
                    w_rp1w_nxt   = 1'b0;
                    w_rp2w_nxt   = 1'b0;
                    w_rtie_nxt   = 1'b0;
                    w_s1_nxt     = '0;
                    w_s2_nxt     = '0;
                    w_rc_nxt     = '0;
                    w_winner_nxt = 2'b00;
                end
            end

            S_COLLECT: begin
                // A held player is ignored entirely, so a move cannot change
                if (p1_valid && !r_h1) begin
                    if (w_p1_legal) begin
                        w_m1_nxt     = p1_move;
                        w_h1_nxt     = 1'b1;
                        w_p1_ack_nxt = 1'b1;
                    end else begin
                        w_p1_err_nxt = 1'b1;
                    end
                end
                if (p2_valid && !r_h2) begin
                    if (w_p2_legal) begin
                        w_m2_nxt     = p2_move;
                        w_h2_nxt     = 1'b1;
                        w_p2_ack_nxt = 1'b1;
                    end else begin
                        w_p2_err_nxt = 1'b1;
                    end
                end
                if ((r_h1 || w_acc1) && (r_h2 || w_acc2)) begin
                    w_state_nxt = S_JUDGE;
                end
            end

            S_JUDGE: begin
                w_rp1w_nxt       = w_j_p1win;
                w_rp2w_nxt       = w_j_p2win;
                w_rtie_nxt       = w_j_tie;
                w_round_done_nxt = 1'b1;
                if (w_j_p1win) begin
                    w_s1_nxt = r_s1 + c_SCORE_1;
                end
                if (w_j_p2win) begin
                    w_s2_nxt = r_s2 + c_SCORE_1;
                end
                if (r_rc != c_RND_MAX) begin
                    w_rc_nxt = r_rc + c_RND_1;
                end
                w_state_nxt = S_RESULT;
            end

            S_RESULT: begin
                w_h1_nxt = 1'b0;
                w_h2_nxt = 1'b0;
                if (r_s1 == c_TARGET) begin
                    w_state_nxt  = S_DONE;
                    w_winner_nxt = 2'b01;
                end else if (r_s2 == c_TARGET) begin
                    w_state_nxt  = S_DONE;
                    w_winner_nxt = 2'b10;
                end else begin
                    w_state_nxt  = S_COLLECT;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Status flags follow the state being entered so they stay registered
        w_match_done_nxt = (w_state_nxt == S_DONE);
        w_busy_nxt       = (w_state_nxt == S_COLLECT) || (w_state_nxt == S_JUDGE) ||
                           (w_state_nxt == S_RESULT);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m1         <= 3'd0;
            r_m2         <= 3'd0;
            r_h1         <= 1'b0;
            r_h2         <= 1'b0;
            r_p1_ack     <= 1'b0;
            r_p2_ack     <= 1'b0;
            r_p1_err     <= 1'b0;
            r_p2_err     <= 1'b0;
            r_round_done <= 1'b0;
            r_rp1w       <= 1'b0;
            r_rp2w       <= 1'b0;
            r_rtie       <= 1'b0;
            r_s1         <= '0;
            r_s2         <= '0;
            r_rc         <= '0;
            r_match_done <= 1'b0;
            r_winner     <= 2'b00;
            r_busy       <= 1'b0;
        end else begin
            r_m1         <= w_m1_nxt;
            r_m2         <= w_m2_nxt;
            r_h1         <= w_h1_nxt;
            r_h2         <= w_h2_nxt;
            r_p1_ack     <= w_p1_ack_nxt;
            r_p2_ack     <= w_p2_ack_nxt;
            r_p1_err     <= w_p1_err_nxt;
            r_p2_err     <= w_p2_err_nxt;
            r_round_done <= w_round_done_nxt;
            r_rp1w       <= w_rp1w_nxt;
            r_rp2w       <= w_rp2w_nxt;
            r_rtie       <= w_rtie_nxt;
            r_s1         <= w_s1_nxt;
            r_s2         <= w_s2_nxt;
            r_rc         <= w_rc_nxt;
            r_match_done <= w_match_done_nxt;
            r_winner     <= w_winner_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    assign p1_ack       = r_p1_ack;
    assign p2_ack       = r_p2_ack;
    assign p1_err       = r_p1_err;
    assign p2_err       = r_p2_err;
    assign round_done   = r_round_done;
    assign round_p1win  = r_rp1w;
    assign round_p2win  = r_rp2w;
    assign round_tie    = r_rtie;
    assign p1_score     = r_s1;
    assign p2_score     = r_s2;
    assign round_cnt    = r_rc;
    assign match_done   = r_match_done;
    assign match_winner = r_winner;
    assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rps_match_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_rps_match_controller
// Brief    : Directed self-checking bench for rps_match_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rps_match_controller;

    localparam logic [2:0] ROCK     = 3'b001;
    localparam logic [2:0] PAPER    = 3'b010;
    localparam logic [2:0] SCISSORS = 3'b011;
    localparam logic [2:0] LIZARD   = 3'b100;
    localparam logic [2:0] SPOCK    = 3'b101;

    logic       clk = 1'b0;
    logic       reset, start, p1_valid, p2_valid;
    logic [2:0] p1_move, p2_move;
    logic       p1_ack, p2_ack, p1_err, p2_err, round_done;
    logic       round_p1win, round_p2win, round_tie, match_done, busy;
    logic [2:0] p1_score, p2_score;
    logic [3:0] round_cnt;
    logic [1:0] match_winner;

    int n_checks = 0;
    int n_fail   = 0;
    int n_tie = 0, n_p1 = 0, n_p2 = 0;

    always #5 clk = ~clk;

    rps_match_controller #(.WIN_TARGET(3), .SCORE_W(3), .RND_W(4)) dut (
        .clk(clk), .reset(reset), .start(start),
        .p1_valid(p1_valid), .p1_move(p1_move),
        .p2_valid(p2_valid), .p2_move(p2_move),
        .p1_ack(p1_ack), .p2_ack(p2_ack), .p1_err(p1_err), .p2_err(p2_err),
        .round_done(round_done), .round_p1win(round_p1win),
        .round_p2win(round_p2win), .round_tie(round_tie),
        .p1_score(p1_score), .p2_score(p2_score), .round_cnt(round_cnt),
        .match_done(match_done), .match_winner(match_winner), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Independent rule model: in the cycle Rock, Scissors, Lizard, Paper,
    // Spock every move beats the next two entries
    function automatic int cyc_idx(input logic [2:0] m);
        case (m)
            ROCK:     return 0;
            SCISSORS: return 1;
            LIZARD:   return 2;
            PAPER:    return 3;
            default:  return 4;
        endcase
    endfunction

    function automatic int outcome(input logic [2:0] a, input logic [2:0] b);
        int d;
        d = (cyc_idx(b) - cyc_idx(a) + 5) % 5;
        if (d == 0) return 0;
        if (d <= 2) return 1;
        return 2;
    endfunction

    // Both players move in the same cycle; exits one edge after round_done
    task automatic play_round(input logic [2:0] a, input logic [2:0] b,
                              input logic e1, input logic e2, input logic et);
        p1_valid = 1'b1; p1_move = a;
        p2_valid = 1'b1; p2_move = b;
        tick();
        p1_valid = 1'b0; p2_valid = 1'b0;
        check("p1_ack", 32'(p1_ack), 32'd1);
        check("p2_ack", 32'(p2_ack), 32'd1);
        tick();
        check("round_done", 32'(round_done), 32'd1);
        check("round_p1win", 32'(round_p1win), 32'(e1));
        check("round_p2win", 32'(round_p2win), 32'(e2));
        check("round_tie", 32'(round_tie), 32'(et));
        if (round_tie) n_tie++;
        if (round_p1win) n_p1++;
        if (round_p2win) n_p2++;
        tick();
        check("round_done_pulse", 32'(round_done), 32'd0);
    endtask

    initial begin
        int s1, s2, oc;
        reset = 1'b1; start = 1'b0;
        p1_valid = 1'b0; p2_valid = 1'b0; p1_move = 3'd0; p2_move = 3'd0;
        tick(); tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_match_done", 32'(match_done), 32'd0);
        check("rst_p1_score", 32'(p1_score), 32'd0);
        check("rst_round_cnt", 32'(round_cnt), 32'd0);
        reset = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Simultaneous moves, p1 wins
        pulse_start();
        check("start_busy", 32'(busy), 32'd1);
        play_round(ROCK, SCISSORS, 1'b1, 1'b0, 1'b0);
        check("r1_p1_score", 32'(p1_score), 32'd1);
        check("r1_p2_score", 32'(p2_score), 32'd0);
        check("r1_round_cnt", 32'(round_cnt), 32'd1);

        // Illegal code, then a held move that cannot be changed
        p1_valid = 1'b1; p1_move = 3'b110;
        tick();
        check("ill_p1_err", 32'(p1_err), 32'd1);
        check("ill_p1_ack", 32'(p1_ack), 32'd0);
        p1_move = PAPER;
        tick();
        check("paper_ack", 32'(p1_ack), 32'd1);
        check("paper_err", 32'(p1_err), 32'd0);
        p1_move = SPOCK;
        tick();
        p1_valid = 1'b0;
        check("resend_ack", 32'(p1_ack), 32'd0);
        check("resend_err", 32'(p1_err), 32'd0);
        p2_valid = 1'b1; p2_move = SPOCK;
        tick();
        p2_valid = 1'b0;
        check("p2_spock_ack", 32'(p2_ack), 32'd1);
        tick();
        check("held_round_done", 32'(round_done), 32'd1);
        check("held_p1win", 32'(round_p1win), 32'd1);
        check("held_p2win", 32'(round_p2win), 32'd0);
        check("held_p1_score", 32'(p1_score), 32'd2);
        tick();

        // Tie leaves scores alone but counts the round
        play_round(LIZARD, LIZARD, 1'b0, 1'b0, 1'b1);
        check("tie_p1_score", 32'(p1_score), 32'd2);
        check("tie_p2_score", 32'(p2_score), 32'd0);
        check("tie_round_cnt", 32'(round_cnt), 32'd3);
        check("tie_held", 32'(round_tie), 32'd1);

        // p2 takes three rounds and the match
        play_round(ROCK, SPOCK, 1'b0, 1'b1, 1'b0);
        play_round(PAPER, LIZARD, 1'b0, 1'b1, 1'b0);
        check("p2_two_done", 32'(match_done), 32'd0);
        play_round(LIZARD, ROCK, 1'b0, 1'b1, 1'b0);
        check("win_p2_score", 32'(p2_score), 32'd3);
        check("win_p1_score", 32'(p1_score), 32'd2);
        check("win_match_done", 32'(match_done), 32'd1);
        check("win_winner", 32'(match_winner), 32'd2);
        check("win_busy", 32'(busy), 32'd0);
        check("win_round_cnt", 32'(round_cnt), 32'd6);

        // Moves in DONE are ignored
        p1_valid = 1'b1; p1_move = ROCK; p2_valid = 1'b1; p2_move = PAPER;
        tick(); tick();
        p1_valid = 1'b0; p2_valid = 1'b0;
        check("done_p1_ack", 32'(p1_ack), 32'd0);
        check("done_p2_ack", 32'(p2_ack), 32'd0);
        check("done_round_done", 32'(round_done), 32'd0);
        check("done_held", 32'(match_done), 32'd1);
        check("done_p2_score", 32'(p2_score), 32'd3);

        // Restart clears scores
        pulse_start();
        check("rs_match_done", 32'(match_done), 32'd0);
        check("rs_busy", 32'(busy), 32'd1);
        check("rs_p2_score", 32'(p2_score), 32'd0);
        check("rs_p1_score", 32'(p1_score), 32'd0);
        check("rs_winner", 32'(match_winner), 32'd0);

        // All 25 legal pairs against the cyclic model
        s1 = 0; s2 = 0;
        n_tie = 0; n_p1 = 0; n_p2 = 0;
        for (int i = 1; i <= 5; i++) begin
            for (int j = 1; j <= 5; j++) begin
                oc = outcome(3'(i), 3'(j));
                play_round(3'(i), 3'(j), oc == 1, oc == 2, oc == 0);
                if (oc == 1) s1++;
                if (oc == 2) s2++;
                check("sw_p1_score", 32'(p1_score), 32'(s1));
                check("sw_p2_score", 32'(p2_score), 32'(s2));
                if (s1 == 3 || s2 == 3) begin
                    check("sw_match_done", 32'(match_done), 32'd1);
                    check("sw_winner", 32'(match_winner), (s1 == 3) ? 32'd1 : 32'd2);
                    pulse_start();
                    s1 = 0; s2 = 0;
                end else begin
                    check("sw_not_done", 32'(match_done), 32'd0);
                end
            end
        end
        check("sweep_ties", 32'(n_tie), 32'd5);
        check("sweep_p1", 32'(n_p1), 32'd10);
        check("sweep_p2", 32'(n_p2), 32'd10);

        // Round counter saturates at all-ones
        reset = 1'b1; tick(); reset = 1'b0;
        pulse_start();
        for (int k = 1; k <= 16; k++) begin
            play_round(SPOCK, SPOCK, 1'b0, 1'b0, 1'b1);
            if (k >= 15) check("sat_round_cnt", 32'(round_cnt), 32'd15);
        end

        // Reset mid-round wipes the hold and every output
        p1_valid = 1'b1; p1_move = ROCK;
        tick();
        p1_valid = 1'b0;
        check("mid_p1_ack", 32'(p1_ack), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_round_tie", 32'(round_tie), 32'd0);
        check("mid_round_cnt", 32'(round_cnt), 32'd0);
        check("mid_p1_ack_clr", 32'(p1_ack), 32'd0);
        check("mid_match_done", 32'(match_done), 32'd0);
        pulse_start();
        p2_valid = 1'b1; p2_move = ROCK;
        tick();
        p2_valid = 1'b0;
        check("mid_p2_ack", 32'(p2_ack), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("mid_no_round", 32'(round_done), 32'd0);
        end
        check("mid_still_busy", 32'(busy), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
